// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester, dmem and debug signals of dmem_arbiter
// slave is the arbiter side; master is the requesters plus the dmem instance.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic [ADDR_W-1:0] address_dmem;
  logic [DATA_W-1:0] data;
  logic              wren;
  logic [DATA_W-1:0] q_dmem;
  logic [CNT_W-1:0]  conflict_cnt;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, q_dmem,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           address_dmem, data, wren, conflict_cnt
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, q_dmem,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           address_dmem, data, wren, conflict_cnt
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester arbiter in front of a single-port synchronous dmem
// Registers the winning command onto dmem and steers read data back by a {valid,id} pipe.
module dmem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0,
  parameter int CNT_W      = 16
) (
  input logic           clock,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  logic              last_winner_q, last_winner_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wren_q, wren_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s1_id_q, s1_id_d;
  logic              s2_valid_q, s2_valid_d;
  logic              s2_id_q, s2_id_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              contend;
  logic              gnt0;
  logic              gnt1;
  logic              accept;
  logic              win_id;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              rvalid0;
  logic              rvalid1;

  assign contend = bus.req0 & bus.req1;

  // Ties go to the requester that did not win last; last_winner resets to 1 so 0 wins first.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (contend) begin
        if ((FIXED_PRIO != 0) || last_winner_q) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end else begin
        gnt0 = bus.req0;
        gnt1 = bus.req1;
      end
    end
  end

  assign accept = (bus.req0 & gnt0) | (bus.req1 & gnt1);
  assign win_id = gnt1;

  always_comb begin
    win_we    = bus.we0;
    win_addr  = bus.addr0;
    win_wdata = bus.wdata0;
    if (win_id) begin
      win_we    = bus.we1;
      win_addr  = bus.addr1;
      win_wdata = bus.wdata1;
    end
  end

  always_comb begin
    last_winner_d = last_winner_q;
    address_d     = address_q;
    data_d        = data_q;
    wren_d        = 1'b0;
    s1_valid_d    = 1'b0;
    s1_id_d       = s1_id_q;
    s2_valid_d    = s1_valid_q;
    s2_id_d       = s1_id_q;
    cnt_d         = cnt_q;
    if (accept) begin
      last_winner_d = win_id;
      address_d     = win_addr;
      data_d        = win_wdata;
      wren_d        = win_we;
      s1_valid_d    = ~win_we;
      s1_id_d       = win_id;
    end
    if (contend && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_winner_q <= 1'b1;
      address_q     <= '0;
      data_q        <= '0;
      wren_q        <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_id_q       <= 1'b0;
      s2_valid_q    <= 1'b0;
      s2_id_q       <= 1'b0;
      cnt_q         <= '0;
    end else begin
      last_winner_q <= last_winner_d;
      address_q     <= address_d;
      data_q        <= data_d;
      wren_q        <= wren_d;
      s1_valid_q    <= s1_valid_d;
      s1_id_q       <= s1_id_d;
      s2_valid_q    <= s2_valid_d;
      s2_id_q       <= s2_id_d;
      cnt_q         <= cnt_d;
    end
  end

  assign rvalid0 = s2_valid_q & ~s2_id_q;
  assign rvalid1 = s2_valid_q & s2_id_q;

  assign bus.gnt0         = gnt0;
  assign bus.gnt1         = gnt1;
  assign bus.rvalid0      = rvalid0;
  assign bus.rvalid1      = rvalid1;
  assign bus.rdata0       = rvalid0 ? bus.q_dmem : '0;
  assign bus.rdata1       = rvalid1 ? bus.q_dmem : '0;
  assign bus.address_dmem = address_q;
  assign bus.data         = data_q;
  assign bus.wren         = wren_q;
  assign bus.conflict_cnt = cnt_q;

endmodule
